// File: rtl/pulse_stretch.sv
// pulse_stretch: turns single-cycle event pulses into fixed-length visible
// pulses (ON_CYCLES high, then GAP_CYCLES forced low) per channel. Events that
// arrive while a channel is busy are counted and replayed one at a time; a
// sticky ovf flag records any event dropped because the counter was full.
// Build option: define PULSE_STRETCH_EDGE_IN_EN to treat x as a level input
// and take an event only on its rising edge.
module pulse_stretch #(
    parameter int unsigned WIDTH      = 1,
    parameter int unsigned ON_CYCLES  = 5000000,
    parameter int unsigned GAP_CYCLES = 5000000,
    parameter int unsigned PEND_W     = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] ovf
);

    localparam int unsigned MAX_CYCLES = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int unsigned TW         = $clog2(MAX_CYCLES + 1);
    localparam logic [TW-1:0]     ON_RELOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0]     GAP_RELOAD = TW'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    logic [WIDTH-1:0] ev;

`ifdef PULSE_STRETCH_EDGE_IN_EN
    logic [WIDTH-1:0] x_d;

    // One-cycle delayed copy of x for rising-edge detection
    always_ff @(posedge clk) begin
        if (!rstn) begin
            x_d <= '0;
        end else begin
            x_d <= x;
        end
    end

    assign ev = x & ~x_d;
`else
    assign ev = x;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        state_t            state;
        logic [TW-1:0]     timer;
        logic [PEND_W-1:0] pend;
        logic              y_r;
        logic              ovf_r;
        logic              gap_exp;
        logic              inc;
        logic              dec;

        // Queue bookkeeping: an event at GAP expiry with nothing queued starts ON directly
        always_comb begin
            gap_exp = 1'b0;
            inc     = 1'b0;
            dec     = 1'b0;
            gap_exp = (state == GAP) && (timer == '0);
            inc     = ev[i] && (state != IDLE) && !(gap_exp && (pend == '0));
            dec     = gap_exp && (pend != '0);
        end

        // Per-channel IDLE/ON/GAP sequencer with pending counter and sticky overflow
        always_ff @(posedge clk) begin
            if (!rstn) begin
                state <= IDLE;
                timer <= '0;
                pend  <= '0;
                y_r   <= 1'b0;
                ovf_r <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ev[i]) begin
                            state <= ON;
                            timer <= ON_RELOAD;
                            y_r   <= 1'b1;
                        end
                    end
                    ON: begin
                        if (timer != '0) begin
                            timer <= timer - TW'(1);
                        end else begin
                            state <= GAP;
                            timer <= GAP_RELOAD;
                            y_r   <= 1'b0;
                        end
                    end
                    GAP: begin
                        if (timer != '0) begin
                            timer <= timer - TW'(1);
                        end else if ((pend != '0) || ev[i]) begin
                            state <= ON;
                            timer <= ON_RELOAD;
                            y_r   <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        timer <= '0;
                        y_r   <= 1'b0;
                    end
                endcase

                if (inc && !dec) begin
                    if (pend == PEND_MAX) begin
                        ovf_r <= 1'b1;
                    end else begin
                        pend <= pend + PEND_W'(1);
                    end
                end else if (dec && !inc) begin
                    pend <= pend - PEND_W'(1);
                end
            end
        end

        assign y[i]   = y_r;
        assign ovf[i] = ovf_r;
    end

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch (WIDTH=2, ON=3, GAP=2, PEND_W=2).
// Each table row is one scenario: per-cycle input masks and expected output
// masks (bit c = cycle c after reset release). Expectations follow the build
// option PULSE_STRETCH_EDGE_IN_EN when it is defined.
module tb_pulse_stretch;

    localparam int unsigned NCYC = 60;
    localparam int unsigned NROW = 7;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] x;
    logic [1:0] y;
    logic [1:0] ovf;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        string       name;
        logic [63:0] x0;
        logic [63:0] x1;
        logic [63:0] rst;
        logic [63:0] y0;
        logic [63:0] y1;
        logic [63:0] o0;
        logic [63:0] o1;
    } vec_t;

    vec_t tbl [NROW];

    pulse_stretch #(
        .WIDTH      (2),
        .ON_CYCLES  (3),
        .GAP_CYCLES (2),
        .PEND_W     (2)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .x    (x),
        .y    (y),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string name, input int c, input logic [1:0] act, input logic [1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %b want %b", name, c, act, exp);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        x    = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_y", -1, y, 2'b00);
        chk("reset_ovf", -1, ovf, 2'b00);
        rstn = 1'b1;
    endtask

    initial begin
        vec_t v;
        int   hi0;
        int   hi1;
        int   budget;

        // single event
        tbl[0] = '{"single", rng(10,10), '0, '0, rng(11,13), '0, '0, '0};
        // gap-expiry event with empty queue, plus independent event on ch1
        tbl[3] = '{"gap_expiry", rng(10,10) | rng(15,15), rng(20,20), '0,
                   rng(11,13) | rng(16,18), rng(21,23), '0, '0};
        // reset mid-ON with events queued: no replay
        tbl[4] = '{"reset_mid", rng(10,12), '0, rng(12,12), rng(11,12), '0, '0, '0};
`ifdef PULSE_STRETCH_EDGE_IN_EN
        tbl[1] = '{"queued", rng(10,12), '0, '0, rng(11,13), '0, '0, '0};
        tbl[2] = '{"overflow", rng(10,14), '0, '0, rng(11,13), '0, '0, '0};
        tbl[5] = '{"held_level", '0, rng(10,29) | rng(40,40), '0,
                   '0, rng(11,13) | rng(41,43), '0, '0};
        tbl[6] = '{"reset_ovf", rng(10,14), '0, rng(20,20), rng(11,13), '0, '0, '0};
`else
        tbl[1] = '{"queued", rng(10,12), '0, '0,
                   rng(11,13) | rng(16,18) | rng(21,23), '0, '0, '0};
        tbl[2] = '{"overflow", rng(10,14), '0, '0,
                   rng(11,13) | rng(16,18) | rng(21,23) | rng(26,28), '0, rng(15,63), '0};
        tbl[5] = '{"held_level", '0, rng(10,29) | rng(40,40), '0,
                   '0, rng(11,13) | rng(16,18) | rng(21,23) | rng(26,28) |
                   rng(31,33) | rng(36,38) | rng(41,43) | rng(46,48), '0, rng(15,63)};
        tbl[6] = '{"reset_ovf", rng(10,14), '0, rng(20,20),
                   rng(11,13) | rng(16,18), '0, rng(15,20), '0};
`endif

        for (int r = 0; r < NROW; r++) begin
            v = tbl[r];
            do_reset();
            for (int c = 0; c < NCYC; c++) begin
                @(posedge clk);
                #1;
                chk({v.name, "_y"}, c, y, {v.y1[c], v.y0[c]});
                chk({v.name, "_ovf"}, c, ovf, {v.o1[c], v.o0[c]});
                x    = {v.x1[c], v.x0[c]};
                rstn = ~v.rst[c];
            end
        end

        // Both channels fire together: each must stay high exactly ON cycles
        do_reset();
        @(posedge clk);
        #1;
        x = 2'b11;
        @(posedge clk);
        #1;
        x      = 2'b00;
        hi0    = 0;
        hi1    = 0;
        budget = 0;
        while ((y != 2'b00 || budget == 0) && budget < 20) begin
            hi0 += int'(y[0]);
            hi1 += int'(y[1]);
            budget++;
            @(posedge clk);
            #1;
        end
        chk("dual_timeout", budget, 2'(budget < 20), 2'b01);
        chk("dual_len0", 0, 2'(hi0), 2'd3);
        chk("dual_len1", 1, 2'(hi1), 2'd3);
        chk("dual_ovf", 0, ovf, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
